microcode_sequencer: RTL

- Sequences the control-unit micro-program counter (uPC) for one core of the multicore matrix-multiply engine.
- Each cycle it decodes the current micro-word's branch field and the zero flag into a 2-bit next-address select: 0 = increment, 1 = jump, 2 = map.
- It registers the chosen next address and runs a start/halt/done handshake with the core-level controller.
- It sits between the control store (driven by upc) and the instruction decode/map ROM (supplies map_addr).

---
 rtl/microseq_pkg.sv | 45 ++++
 rtl/microcode_sequencer_upc_next_mux.sv | 25 ++
 rtl/microcode_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/microseq_pkg.sv
// Shared encodings for the microcode sequencer: branch types, next-address
// select codes, FSM state codes and the default micro-address width.
// Build option: MICROSEQ_CALL_RET_EN enables the one-entry CALL/RET return
// register in the top module.
package microseq_pkg;

  // Default micro-address width
  localparam int ADDR_W_DEFAULT = 16;

  // Branch field of the current micro-word
  typedef enum logic [2:0] {
    BR_NEXT = 3'd0,
    BR_JUMP = 3'd1,
    BR_MAP  = 3'd2,
    BR_JZ   = 3'd3,
    BR_JNZ  = 3'd4,
    BR_HALT = 3'd5,
    BR_CALL = 3'd6,
    BR_RET  = 3'd7
  } br_type_e;

  // Next-address select codes; code 3 is never produced
  localparam logic [1:0] SEL_INC  = 2'd0;
  localparam logic [1:0] SEL_JUMP = 2'd1;
  localparam logic [1:0] SEL_MAP  = 2'd2;

  // Sequencer FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // True when a conditional branch (JZ/JNZ) takes its jump target.
  // Unconditional or non-branch types return 0.
  function automatic logic cond_taken(input logic [2:0] br, input logic zf);
    logic taken;
    taken = 1'b0;
    if (br == BR_JZ) begin
      taken = zf;
    end else if (br == BR_JNZ) begin
      taken = ~zf;
    end
    return taken;
  endfunction

endpackage

// File: rtl/microcode_sequencer_upc_next_mux.sv
// Next micro-address selector: picks increment, jump or map address by sel.
// The unused code 3 falls back to the jump path.
module upc_next_mux
  import microseq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [ADDR_W-1:0] map_addr,
  output logic [ADDR_W-1:0] next_addr
);

  // 3:1 address selection, jump path as the default leg
  always_comb begin
    next_addr = jump_addr;
    case (sel)
      SEL_INC:  next_addr = inc_addr;
      SEL_MAP:  next_addr = map_addr;
      default:  next_addr = jump_addr;
    endcase
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Micro-program counter sequencer for one matrix-multiply core.
// Decodes the current micro-word's branch field and the zero flag into a
// next-address select, registers the next uPC, and runs the
// start / busy / done handshake with the core controller.
// Build option: MICROSEQ_CALL_RET_EN adds a one-entry return register so
// CALL/RET work; without it CALL and RET behave like NEXT.
module microcode_sequencer
  import microseq_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic [2:0]        br_type,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] map_addr,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] upc,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;

  logic [1:0]        sel_dec;
  logic              halt_req;
  logic              advance;
  logic [ADDR_W-1:0] inc_addr;
  logic [ADDR_W-1:0] jump_path_addr;
  logic [ADDR_W-1:0] next_addr;

`ifdef MICROSEQ_CALL_RET_EN
  logic [ADDR_W-1:0] ret_q, ret_d;
  logic              call_req;
  logic              ret_req;
`endif

  // Increment wraps modulo 2^ADDR_W with no carry out
  assign inc_addr = upc_q + ADDR_ONE;

  // The uPC only moves while running and not stalled
  assign advance = (state_q == ST_RUN) && !stall;

  // Branch decode: select code, halt request and jump-path source.
  // Decode is live while stalled so sel always reflects the current word.
  always_comb begin
    sel_dec        = SEL_INC;
    halt_req       = 1'b0;
    jump_path_addr = jump_target;
`ifdef MICROSEQ_CALL_RET_EN
    call_req       = 1'b0;
    ret_req        = 1'b0;
`endif
    if (state_q == ST_RUN) begin
      case (br_type)
        BR_NEXT: sel_dec = SEL_INC;
        BR_JUMP: sel_dec = SEL_JUMP;
        BR_MAP:  sel_dec = SEL_MAP;
        BR_JZ,
        BR_JNZ:  sel_dec = cond_taken(br_type, zero_flag) ? SEL_JUMP : SEL_INC;
        BR_HALT: begin
          sel_dec  = SEL_INC;
          halt_req = 1'b1;
        end
`ifdef MICROSEQ_CALL_RET_EN
        BR_CALL: begin
          sel_dec  = SEL_JUMP;
          call_req = 1'b1;
        end
        // The return address leaves on the jump leg of the mux
        BR_RET: begin
          sel_dec        = SEL_JUMP;
          ret_req        = 1'b1;
          jump_path_addr = ret_q;
        end
`else
        BR_CALL,
        BR_RET:  sel_dec = SEL_INC;
`endif
        default: sel_dec = SEL_INC;
      endcase
    end
  end

  upc_next_mux #(
    .ADDR_W    (ADDR_W)
  ) u_next_mux (
    .sel       (sel_dec),
    .inc_addr  (inc_addr),
    .jump_addr (jump_path_addr),
    .map_addr  (map_addr),
    .next_addr (next_addr)
  );

  // FSM and uPC next-state: stall outranks every branch type, HALT included
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          upc_d   = START_ADDR;
        end
      end
      ST_RUN: begin
        if (advance) begin
          if (halt_req) begin
            state_d = ST_DONE;
          end else begin
            upc_d = next_addr;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and uPC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      upc_q   <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
    end
  end

`ifdef MICROSEQ_CALL_RET_EN
  // Return register next value: a CALL captures the fall-through address;
  // nested calls simply overwrite it
  always_comb begin
    ret_d = ret_q;
    if (advance && call_req) begin
      ret_d = inc_addr;
    end
  end

  // One-entry return register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q <= '0;
    end else begin
      ret_q <= ret_d;
    end
  end
`endif

  assign upc  = upc_q;
  assign sel  = sel_dec;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule
